// File: rtl/lcd_write_scheduler.sv
// HD44780-style 8-bit LCD bus owner: power-up init, then round-robin character writes with
// cursor-address elision. Every output is registered; enable and wait timing count clk cycles.
module lcd_write_scheduler #(
    parameter int unsigned NUM_REQ           = 2,
    parameter int unsigned POWERUP_CYCLES    = 800000,
    parameter int unsigned EN_CYCLES         = 25,
    parameter int unsigned WAIT_CYCLES       = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 80000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_line,
    input  logic [4*NUM_REQ-1:0]   req_col,
    input  logic [8*NUM_REQ-1:0]   req_char,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   init_done,
    output logic                   busy,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_en,
    output logic [7:0]             lcd_data
);

    localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] PwrLast = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] EnLast  = 32'(EN_CYCLES);
    localparam logic [31:0] OpLast  = 32'(EN_CYCLES + WAIT_CYCLES);
    localparam logic [31:0] ClrLast = 32'(EN_CYCLES + CLEAR_WAIT_CYCLES);

    typedef enum logic [2:0] {
        StPwrWait, StInit, StIdle, StArb, StSetCur, StWrChar
    } state_e;

    state_e               state_q;
    logic [31:0]          cnt_q;
    logic [1:0]           init_idx_q;
    logic [PtrW-1:0]      rr_ptr_q;
    logic                 trk_valid_q, trk_line_q;
    logic [3:0]           trk_col_q;
    logic                 line_q;
    logic [3:0]           col_q;
    logic [7:0]           char_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 init_done_q, busy_q, lcd_rs_q, lcd_en_q;
    logic [7:0]           lcd_data_q;

    logic                 arb_found;
    logic [PtrW-1:0]      arb_idx, rr_next;
    logic                 sel_line, skip_cur;
    logic [3:0]           sel_col;
    logic [7:0]           sel_char, cur_cmd;
    logic [31:0]          op_last;
    logic                 op_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = PtrW'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        rr_next  = (arb_idx == PtrW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        sel_line = req_line[arb_idx];
        sel_col  = req_col[4*arb_idx +: 4];
        sel_char = req_char[8*arb_idx +: 8];
        cur_cmd  = {1'b1, sel_line, 2'b00, sel_col};
        skip_cur = trk_valid_q && (trk_line_q == sel_line) && (trk_col_q == sel_col);
        op_last  = (!lcd_rs_q && lcd_data_q == 8'h01) ? ClrLast : OpLast;
        op_done  = (cnt_q == op_last);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StPwrWait;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            rr_ptr_q    <= '0;
            trk_valid_q <= 1'b0;
            trk_line_q  <= 1'b0;
            trk_col_q   <= '0;
            line_q      <= 1'b0;
            col_q       <= '0;
            char_q      <= '0;
            gnt_q       <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_data_q  <= '0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                StPwrWait: begin
                    if (cnt_q == PwrLast) begin
                        state_q    <= StInit;
                        cnt_q      <= '0;
                        init_idx_q <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= init_cmd(2'd0);
                        busy_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StInit, StSetCur, StWrChar: begin
                    if (!op_done) begin
                        cnt_q    <= cnt_q + 32'd1;
                        lcd_en_q <= (cnt_q < EnLast);
                    end else begin
                        cnt_q    <= '0;
                        lcd_en_q <= 1'b0;
                        if (state_q == StInit) begin
                            if (init_idx_q == 2'd3) begin
                                init_done_q <= 1'b1;
                                busy_q      <= 1'b0;
                                trk_valid_q <= 1'b0;
                                state_q     <= StIdle;
                            end else begin
                                init_idx_q <= init_idx_q + 2'd1;
                                lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                            end
                        end else if (state_q == StSetCur) begin
                            state_q    <= StWrChar;
                            lcd_rs_q   <= 1'b1;
                            lcd_data_q <= char_q;
                        end else begin
                            // No wrap past column 15: the cursor position is unknown there.
                            trk_valid_q <= (col_q != 4'hF);
                            trk_line_q  <= line_q;
                            trk_col_q   <= col_q + 4'd1;
                            busy_q      <= 1'b0;
                            state_q     <= StIdle;
                        end
                    end
                end
                StIdle: begin
                    if (|req) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (arb_found) begin
                        gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
                        rr_ptr_q <= rr_next;
                        line_q   <= sel_line;
                        col_q    <= sel_col;
                        char_q   <= sel_char;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (skip_cur) begin
                            state_q    <= StWrChar;
                            lcd_rs_q   <= 1'b1;
                            lcd_data_q <= sel_char;
                        end else begin
                            state_q    <= StSetCur;
                            lcd_rs_q   <= 1'b0;
                            lcd_data_q <= cur_cmd;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StPwrWait;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: timeline model of bus ops checked every cycle, plus directed
// scenarios with literal expectations on op bytes, busy lengths and grant order.
module tb_lcd_write_scheduler;

    localparam int N   = 2;
    localparam int PWR = 10;
    localparam int EN  = 2;
    localparam int WT  = 4;
    localparam int CLR = 8;
    localparam int INIT_DONE_AT = PWR + 3 * (1 + EN + WT) + (1 + EN + CLR);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_line = '0;
    logic [4*N-1:0] req_col = '0;
    logic [8*N-1:0] req_char = '0;
    logic [N-1:0]   gnt;
    logic           init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0]     lcd_data;

    always #5 clk = ~clk;

    lcd_write_scheduler #(
        .NUM_REQ(N), .POWERUP_CYCLES(PWR), .EN_CYCLES(EN),
        .WAIT_CYCLES(WT), .CLEAR_WAIT_CYCLES(CLR)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_line(req_line), .req_col(req_col),
        .req_char(req_char), .gnt(gnt), .init_done(init_done), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Model: list of bus ops with start cycle; outputs at any cycle follow from the latest op.
    typedef struct {
        int       start;
        bit       rs;
        bit [7:0] data;
    } op_t;

    op_t ops[$];
    int  cyc = 0;
    bit  armed = 0;
    int  free_at, rr, gnt_cyc, gnt_k, tc, m_k, m_t, m_col;
    bit  arb_pend, tv, tl, m_l;
    bit [7:0] m_ch;

    function automatic int op_len(input bit rs, input bit [7:0] d);
        return 1 + EN + ((!rs && d == 8'h01) ? CLR : WT);
    endfunction

    function automatic op_t mk(input int s, input bit rs, input bit [7:0] d);
        op_t o;
        o.start = s;
        o.rs = rs;
        o.data = d;
        return o;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            armed = 1;
            cyc = 0;
            ops.delete();
            ops.push_back(mk(PWR, 0, 8'h38));
            ops.push_back(mk(PWR + 7, 0, 8'h06));
            ops.push_back(mk(PWR + 14, 0, 8'h0C));
            ops.push_back(mk(PWR + 21, 0, 8'h01));
            free_at = INIT_DONE_AT;
            arb_pend = 0;
            rr = 0;
            tv = 0;
            gnt_cyc = -1;
        end else if (armed) begin
            if (cyc >= INIT_DONE_AT) begin
                if (arb_pend) begin
                    arb_pend = 0;
                    m_k = -1;
                    for (int i = 0; i < N; i++)
                        if (m_k < 0 && req[(rr + i) % N]) m_k = (rr + i) % N;
                    if (m_k >= 0) begin
                        m_l = req_line[m_k];
                        m_col = int'(req_col[4*m_k +: 4]);
                        m_ch = req_char[8*m_k +: 8];
                        gnt_cyc = cyc + 1;
                        gnt_k = m_k;
                        rr = (m_k + 1) % N;
                        m_t = cyc + 1;
                        if (!(tv && tl == m_l && tc == m_col)) begin
                            ops.push_back(mk(m_t, 0, 8'h80 + (m_l ? 8'h40 : 8'h00) + 8'(m_col)));
                            m_t += op_len(0, 8'h80);
                        end
                        ops.push_back(mk(m_t, 1, m_ch));
                        m_t += op_len(1, m_ch);
                        free_at = m_t;
                        tv = (m_col != 15);
                        tl = m_l;
                        tc = m_col + 1;
                    end else begin
                        free_at = cyc + 1;
                    end
                end else if (cyc >= free_at && req != 0) begin
                    arb_pend = 1;
                end
            end
            cyc++;
        end
    end

    // Per-cycle compare plus a log of what the DUT actually strobed.
    logic [8:0] dut_ops[$];
    int  busy_cnt = 0;
    int  done_cyc = -1;
    bit  prev_en = 0, prev_done = 0;
    bit  e_rs, e_en, e_busy;
    bit [7:0] e_data;
    int  off;

    always @(negedge clk) begin
        if (armed) begin
            e_rs = 0; e_data = 8'h00; e_en = 0; e_busy = 0;
            foreach (ops[i]) begin
                if (ops[i].start <= cyc) begin
                    off = cyc - ops[i].start;
                    e_rs = ops[i].rs;
                    e_data = ops[i].data;
                    e_en = (off >= 1 && off <= EN);
                    e_busy = (off < op_len(ops[i].rs, ops[i].data));
                end
            end
            chk($sformatf("lcd_rs@%0d", cyc), 32'(lcd_rs), 32'(e_rs));
            chk($sformatf("lcd_data@%0d", cyc), 32'(lcd_data), 32'(e_data));
            chk($sformatf("lcd_en@%0d", cyc), 32'(lcd_en), 32'(e_en));
            chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
            chk($sformatf("lcd_rw@%0d", cyc), 32'(lcd_rw), 32'd0);
            chk($sformatf("init_done@%0d", cyc), 32'(init_done), 32'(cyc >= INIT_DONE_AT));
            chk($sformatf("gnt@%0d", cyc), 32'(gnt), (cyc == gnt_cyc) ? (32'd1 << gnt_k) : 32'd0);
            if (lcd_en && !prev_en) dut_ops.push_back({lcd_rs, lcd_data});
            if (busy) busy_cnt++;
            if (init_done && !prev_done) done_cyc = cyc;
            prev_en = lcd_en;
            prev_done = init_done;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (init_done !== 1'b1 && n < 300) begin tick(); n++; end
        if (n >= 300) timeout(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin tick(); n++; end
        if (n >= 300) timeout(name);
    endtask

    task automatic do_req(input int k, input bit l, input bit [3:0] col, input bit [7:0] ch);
        int n = 0;
        req_line[k] = l;
        req_col[4*k +: 4] = col;
        req_char[8*k +: 8] = ch;
        req[k] = 1'b1;
        do begin tick(); n++; end while (gnt[k] !== 1'b1 && n < 300);
        if (n >= 300) timeout($sformatf("gnt%0d", k));
        req[k] = 1'b0;
    endtask

    function automatic logic [31:0] op_at(input int i);
        return (i < dut_ops.size()) ? 32'(dut_ops[i]) : 32'hFFFF;
    endfunction

    task automatic chk_init(input string tag);
        chk({tag, "_nops"}, 32'(dut_ops.size()), 32'd4);
        chk({tag, "_op0"}, op_at(0), 32'h038);
        chk({tag, "_op1"}, op_at(1), 32'h006);
        chk({tag, "_op2"}, op_at(2), 32'h00C);
        chk({tag, "_op3"}, op_at(3), 32'h001);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd42);
    endtask

    int order[4];
    int ng, n;

    initial begin
        repeat (3) tick();
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        dut_ops.delete();
        reset = 1'b1;

        // 1: init sequence, init_done at cycle 42
        wait_init("init1");
        chk_init("s1");

        // 2: line 1 col 3 -> cursor 0xC3 then data 0x41, 14 busy cycles
        tick();
        dut_ops.delete(); busy_cnt = 0;
        do_req(0, 1'b1, 4'd3, 8'h41);
        wait_idle("idle2");
        chk("s2_nops", 32'(dut_ops.size()), 32'd2);
        chk("s2_op0", op_at(0), 32'h0C3);
        chk("s2_op1", op_at(1), 32'h141);
        chk("s2_busy", 32'(busy_cnt), 32'd14);

        // 3: next cell on the same line -> no cursor command
        dut_ops.delete(); busy_cnt = 0;
        do_req(0, 1'b1, 4'd4, 8'h42);
        wait_idle("idle3");
        chk("s3_nops", 32'(dut_ops.size()), 32'd1);
        chk("s3_op0", op_at(0), 32'h142);
        chk("s3_busy", 32'(busy_cnt), 32'd7);

        // 5: col 15 invalidates the tracker, so col 0 needs a cursor command (leaves rr_ptr=0)
        dut_ops.delete();
        do_req(1, 1'b0, 4'd15, 8'h5A);
        wait_idle("idle5a");
        chk("s5a_op0", op_at(0), 32'h08F);
        dut_ops.delete();
        do_req(1, 1'b0, 4'd0, 8'h41);
        wait_idle("idle5b");
        chk("s5_nops", 32'(dut_ops.size()), 32'd2);
        chk("s5_op0", op_at(0), 32'h080);
        chk("s5_op1", op_at(1), 32'h141);

        // 4: both held continuously -> grants alternate 0,1,0,1
        req_line = 2'b10; req_col = {4'd2, 4'd1}; req_char = {8'h31, 8'h30};
        req = 2'b11;
        ng = 0; n = 0;
        while (ng < 4 && n < 400) begin
            tick(); n++;
            if (gnt !== '0) begin order[ng] = (gnt === 2'b10) ? 1 : 0; ng++; end
        end
        req = '0;
        if (ng < 4) timeout("rr_grants");
        wait_idle("idle4");
        chk("s4_g0", 32'(order[0]), 32'd0);
        chk("s4_g1", 32'(order[1]), 32'd1);
        chk("s4_g2", 32'(order[2]), 32'd0);
        chk("s4_g3", 32'(order[3]), 32'd1);

        // 6: reset while lcd_en is high -> enable drops, init replays
        do_req(0, 1'b0, 4'd7, 8'h55);
        n = 0;
        while (lcd_en !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) timeout("en_high6");
        reset = 1'b0;
        tick();
        dut_ops.delete();
        chk("s6_en_drop", 32'(lcd_en), 32'd0);
        chk("s6_init_done", 32'(init_done), 32'd0);
        reset = 1'b1;
        wait_init("init6");
        chk_init("s6");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
